// File: rtl/segdac_pkg.sv
// Shared definitions for the segmented-DAC video driver: calibration FSM
// states and the default parameter set.
package segdac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } cal_state_t;

    localparam int DEF_CHANNELS = 3;
    localparam int DEF_BITS     = 8;
    localparam int DEF_SEG_BITS = 2;
    localparam int DEF_VB_WIDTH = 3;
    localparam int DEF_VB_RESET = 4;
    localparam int DEF_CAL_HOLD = 16;

endpackage

// File: rtl/segdac_thermo_enc.sv
// Binary-to-thermometer encoder for one DAC segment: value k lights the k
// least-significant unit elements.
module segdac_thermo_enc
    import segdac_pkg::*;
#(
    parameter int SEG_BITS = DEF_SEG_BITS
) (
    input  logic [SEG_BITS-1:0]        val,
    output logic [(1<<SEG_BITS)-2:0]   therm
);

    localparam int TW = (1 << SEG_BITS) - 1;

    always_comb begin
        therm = '0;
        for (int i = 0; i < TW; i++) begin
            therm[i] = (int'(val) > i);
        end
    end

endmodule

// File: rtl/segdac_driver.sv
// Pixel-to-segmented-DAC driver with per-channel Vbias registers and a
// slow full-scale calibration ramp shared by all channels.
module segdac_driver
    import segdac_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int BITS     = DEF_BITS,
    parameter int SEG_BITS = DEF_SEG_BITS,
    parameter int VB_WIDTH = DEF_VB_WIDTH,
    parameter int VB_RESET = DEF_VB_RESET,
    parameter int CAL_HOLD = DEF_CAL_HOLD
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [CHANNELS*BITS-1:0]                              pix_rgb,
    input  logic                                                  pix_de,
    input  logic                                                  pix_hsync,
    input  logic                                                  pix_vsync,
    input  logic                                                  cfg_valid,
    output logic                                                  cfg_ready,
    input  logic [$clog2(CHANNELS+1)-1:0]                         cfg_chan,
    input  logic [VB_WIDTH-1:0]                                   cfg_data,
    input  logic                                                  cal_start,
    output logic                                                  cal_busy,
    output logic [CHANNELS*(BITS/SEG_BITS)*((1<<SEG_BITS)-1)-1:0] dac_seg,
    output logic [CHANNELS*VB_WIDTH-1:0]                          dac_vb,
    output logic                                                  hsync_o,
    output logic                                                  vsync_o
);

    localparam int SEGS   = BITS / SEG_BITS;
    localparam int TW     = (1 << SEG_BITS) - 1;
    localparam int CH_W   = SEGS * TW;
    localparam int CW     = $clog2(CHANNELS + 1);
    localparam int HOLD_W = (CAL_HOLD > 1) ? $clog2(CAL_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CAL_HOLD - 1);

    cal_state_t        state_q, state_d;
    logic [BITS-1:0]   code_q, code_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cfg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
        end
    end

    // Each code is held CAL_HOLD cycles; the ramp ends after the last hold of the top code.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (cal_start) begin
                    state_d = RAMP;
                    code_d  = '0;
                    hold_d  = '0;
                end
            end
            RAMP: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (&code_q) begin
                        state_d = IDLE;
                    end else begin
                        code_d = code_q + BITS'(1);
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cal_busy  = (state_q == RAMP);
    assign cfg_ready = ~cal_busy;
    assign cfg_we    = cfg_valid & cfg_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [BITS-1:0]     src;
        logic [CH_W-1:0]     therm;
        logic [CH_W-1:0]     seg_p1;
        logic [VB_WIDTH-1:0] vb_q;

        assign src = cal_busy ? code_q : pix_rgb[c*BITS +: BITS];

        for (genvar s = 0; s < SEGS; s++) begin : g_seg
            segdac_thermo_enc #(
                .SEG_BITS(SEG_BITS)
            ) u_enc (
                .val   (src[s*SEG_BITS +: SEG_BITS]),
                .therm (therm[s*TW +: TW])
            );
        end

        // Stage p1: segment drive register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seg_p1 <= '0;
            end else begin
                seg_p1 <= (cal_busy || pix_de) ? therm : '0;
            end
        end

        // Channel index at or beyond CHANNELS broadcasts to every channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vb_q <= VB_WIDTH'(VB_RESET);
            end else if (cfg_we && (cfg_chan == CW'(c) || cfg_chan >= CW'(CHANNELS))) begin
                vb_q <= cfg_data;
            end
        end

        assign dac_seg[c*CH_W +: CH_W]         = seg_p1;
        assign dac_vb[c*VB_WIDTH +: VB_WIDTH] = vb_q;
    end

    logic hsync_p1, vsync_p1;

    // Stage p1: syncs delayed to stay aligned with segment data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else begin
            hsync_p1 <= pix_hsync;
            vsync_p1 <= pix_vsync;
        end
    end

    assign hsync_o = hsync_p1;
    assign vsync_o = vsync_p1;

endmodule

// File: tb/tb_segdac_driver.sv
// Scoreboard bench for segdac_driver: a default-width instance with a short
// calibration hold, plus a single-channel 6-bit/3-bit-segment instance.
module tb_segdac_driver;

    localparam int CAL_HOLD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] pix_rgb;
    logic        pix_de, pix_hsync, pix_vsync;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_chan;
    logic [2:0]  cfg_data;
    logic        cal_start, cal_busy;
    logic [35:0] dac_seg;
    logic [8:0]  dac_vb;
    logic        hsync_o, vsync_o;

    segdac_driver #(
        .CHANNELS(3), .BITS(8), .SEG_BITS(2), .VB_WIDTH(3), .VB_RESET(4), .CAL_HOLD(CAL_HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_rgb(pix_rgb), .pix_de(pix_de), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_data(cfg_data),
        .cal_start(cal_start), .cal_busy(cal_busy),
        .dac_seg(dac_seg), .dac_vb(dac_vb), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    logic [5:0]  b_rgb;
    logic        b_de, b_hs, b_vs, b_cfg_ready, b_busy, b_hs_o, b_vs_o;
    logic [13:0] b_seg;
    logic [2:0]  b_vb;

    segdac_driver #(
        .CHANNELS(1), .BITS(6), .SEG_BITS(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .pix_rgb(b_rgb), .pix_de(b_de), .pix_hsync(b_hs), .pix_vsync(b_vs),
        .cfg_valid(1'b0), .cfg_ready(b_cfg_ready), .cfg_chan(1'b0), .cfg_data(3'd0),
        .cal_start(1'b0), .cal_busy(b_busy),
        .dac_seg(b_seg), .dac_vb(b_vb), .hsync_o(b_hs_o), .vsync_o(b_vs_o)
    );

    typedef struct packed {
        logic [15:0] id;
        logic [35:0] seg;
        logic        hs;
        logic        vs;
        logic [8:0]  vb;
        logic        busy;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int step_id = 0;

    logic [2:0] m_vb [3];
    logic       m_busy;
    logic [7:0] m_code;
    int         m_hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected segment word while ramping: every segment of every channel shows the code.
    function automatic logic [35:0] ramp_seg(input logic [7:0] code);
        logic [35:0] r;
        int k;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 4; s++) begin
                k = int'(code[2*s +: 2]);
                r[c*12 + s*3 +: 3] = 3'((1 << k) - 1);
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) m_vb[c] = 3'd4;
        m_busy = 1'b0;
        m_code = 8'd0;
        m_hold = 0;
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic cycle(input logic [23:0] rgb, input logic de, input logic hs, input logic vs,
                         input logic cv, input logic [1:0] ch, input logic [2:0] d,
                         input logic cs, input logic [35:0] pix_exp);
        exp_t e;
        @(negedge clk);
        pix_rgb = rgb; pix_de = de; pix_hsync = hs; pix_vsync = vs;
        cfg_valid = cv; cfg_chan = ch; cfg_data = d; cal_start = cs;
        e.seg = m_busy ? ramp_seg(m_code) : pix_exp;
        e.hs = hs;
        e.vs = vs;
        if (cv && !m_busy) begin
            for (int c = 0; c < 3; c++) if (int'(ch) >= 3 || int'(ch) == c) m_vb[c] = d;
        end
        if (m_busy) begin
            if (m_hold == CAL_HOLD - 1) begin
                m_hold = 0;
                if (m_code == 8'd255) m_busy = 1'b0;
                else m_code = m_code + 8'd1;
            end else begin
                m_hold++;
            end
        end else if (cs) begin
            m_busy = 1'b1;
            m_code = 8'd0;
            m_hold = 0;
        end
        e.vb = {m_vb[2], m_vb[1], m_vb[0]};
        e.busy = m_busy;
        e.rdy = ~m_busy;
        e.id = step_id[15:0];
        step_id++;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("seg#%0d", e.id), 64'(dac_seg), 64'(e.seg));
            chk($sformatf("hsync#%0d", e.id), 64'(hsync_o), 64'(e.hs));
            chk($sformatf("vsync#%0d", e.id), 64'(vsync_o), 64'(e.vs));
            chk($sformatf("vb#%0d", e.id), 64'(dac_vb), 64'(e.vb));
            chk($sformatf("busy#%0d", e.id), 64'(cal_busy), 64'(e.busy));
            chk($sformatf("ready#%0d", e.id), 64'(cfg_ready), 64'(e.rdy));
        end
    end

    initial begin
        pix_rgb = '0; pix_de = 1'b0; pix_hsync = 1'b1; pix_vsync = 1'b1;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_data = '0; cal_start = 1'b0;
        b_rgb = '0; b_de = 1'b0; b_hs = 1'b1; b_vs = 1'b1;
        model_reset();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", 64'(dac_seg), 64'h0);
        chk("rst_hsync", 64'(hsync_o), 64'h1);
        chk("rst_vsync", 64'(vsync_o), 64'h1);
        chk("rst_vb", 64'(dac_vb), 64'(9'b100_100_100));
        chk("rst_busy", 64'(cal_busy), 64'h0);
        chk("rst_ready", 64'(cfg_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Pixel path vectors
        cycle(24'h0000E4, 1, 1, 1, 0, 2'd0, 3'd0, 0, 36'h000000EC8);
        cycle(24'hFF1B00, 1, 0, 1, 0, 2'd0, 3'd0, 0, 36'hFFF05F000);
        cycle(24'hFFFFFF, 0, 0, 1, 0, 2'd0, 3'd0, 0, 36'h000000000);
        cycle(24'h555555, 1, 1, 0, 0, 2'd0, 3'd0, 0, 36'h249249249);

        // Vbias writes: single channel then broadcast
        cycle(24'h000000, 1, 1, 1, 1, 2'd1, 3'd7, 0, 36'h000000000);
        cycle(24'h000000, 1, 1, 1, 1, 2'd3, 3'd2, 0, 36'h000000000);

        // Write and calibration start in the same cycle
        cycle(24'h0000E4, 1, 1, 1, 1, 2'd0, 3'd1, 1, 36'h000000EC8);

        // Full ramp with pixel noise, blocked writes and ignored restarts
        for (int i = 0; i < 600 && m_busy; i++) begin
            cycle(24'($urandom), 1'($urandom), 1'(i % 2), (i % 3) != 0,
                  1'b1, 2'($urandom), 3'($urandom), (i % 50) == 7, 36'h0);
        end
        cycle(24'h00E400, 1, 0, 1, 0, 2'd0, 3'd0, 0, 36'h000EC8000);

        // Second ramp, aborted by asynchronous reset around code 37
        cycle(24'h000000, 0, 1, 1, 0, 2'd0, 3'd0, 1, 36'h0);
        for (int i = 0; i < 300 && !(m_code == 8'd37 && m_hold == 1); i++) begin
            cycle(24'h000000, 1, 0, 0, 0, 2'd0, 3'd0, 0, 36'h0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seg", 64'(dac_seg), 64'h0);
        chk("arst_hsync", 64'(hsync_o), 64'h1);
        chk("arst_vsync", 64'(vsync_o), 64'h1);
        chk("arst_vb", 64'(dac_vb), 64'(9'b100_100_100));
        chk("arst_busy", 64'(cal_busy), 64'h0);
        chk("arst_ready", 64'(cfg_ready), 64'h1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(24'h0000E4, 1, 1, 1, 0, 2'd0, 3'd0, 0, 36'h000000EC8);
        cycle(24'h000000, 0, 1, 1, 1, 2'd2, 3'd6, 0, 36'h000000000);
        cycle(24'h000000, 0, 1, 1, 0, 2'd0, 3'd0, 0, 36'h000000000);

        // Single-channel, 3-bit segment instance
        @(negedge clk);
        b_rgb = 6'b101011; b_de = 1'b1; b_hs = 1'b0;
        @(posedge clk);
        #1;
        chk("b_seg_2b", 64'(b_seg), 64'(14'b0011111_0000111));
        chk("b_hsync", 64'(b_hs_o), 64'h0);
        @(negedge clk);
        b_rgb = 6'b000111; b_hs = 1'b1;
        @(posedge clk);
        #1;
        chk("b_seg_07", 64'(b_seg), 64'(14'b0000000_1111111));
        @(negedge clk);
        b_de = 1'b0;
        @(posedge clk);
        #1;
        chk("b_seg_blank", 64'(b_seg), 64'h0);
        chk("b_vb", 64'(b_vb), 64'h4);

        @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
